// File: rtl/midi_parser_pkg.sv
// MIDI package: shared types, constants and helpers for the MIDI byte-stream parser.
// Contents:
//   byte_type_t, message_type_t, note_state_t, controller_t  - enums
//   message_t, note_change_t, control_change_t               - packed payload structs
//   CHANNEL_ANY                                              - channel wildcard constant
//   data_byte_count()                                        - data bytes per message type
//   is_mapped_controller()                                   - controller number in 21..28
package MIDI;

    typedef enum logic {
        DATA   = 1'b0,
        STATUS = 1'b1
    } byte_type_t;

    typedef enum logic [3:0] {
        NONE             = 4'h0,
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE
    } message_type_t;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } note_state_t;

    // Controllers 21..28 drive the synth voice parameters.
    typedef enum logic [6:0] {
        NO_CONTROLLER = 7'd0,
        CUTOFF        = 7'd21,
        RESONANCE     = 7'd22,
        ENV_AMOUNT    = 7'd23,
        ATTACK        = 7'd24,
        DECAY         = 7'd25,
        SUSTAIN       = 7'd26,
        RELEASE       = 7'd27,
        LFO_RATE      = 7'd28
    } controller_t;

    typedef struct packed {
        message_type_t message_type;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;

    typedef struct packed {
        note_state_t state;
        logic [6:0]  note;
        logic [6:0]  velocity;
    } note_change_t;

    typedef struct packed {
        controller_t controller;
        logic [6:0]  value;
    } control_change_t;

    // Wildcard sentinel: one past the highest real channel number.
    localparam logic [4:0] CHANNEL_ANY = 5'h10;

    function automatic logic [1:0] data_byte_count(message_type_t t);
        return (t == PROGRAM_CHANGE || t == CHANNEL_PRESSURE) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic is_mapped_controller(logic [6:0] num);
        return (num >= 7'd21) && (num <= 7'd28);
    endfunction

endpackage

// File: rtl/midi_message_decode.sv
// midi_message_decode: combinational decode of a complete channel message into
// note and controller events.
// Ports:
//   msg      - complete channel message
//   note_hit - msg is NOTE_ON/NOTE_OFF; note holds the decoded event
//   note     - decoded note event
//   cc_hit   - msg is CONTROL_CHANGE for a controller in 21..28
//   cc       - decoded controller event
module midi_message_decode
    import MIDI::*;
(
    input  message_t        msg,
    output logic            note_hit,
    output note_change_t    note,
    output logic            cc_hit,
    output control_change_t cc
);

    always_comb begin
        note_hit = 1'b0;
        note     = '{state: OFF, note: msg.data_byte1, velocity: msg.data_byte2};
        cc_hit   = 1'b0;
        cc       = '{controller: controller_t'(msg.data_byte1), value: msg.data_byte2};
        case (msg.message_type)
            NOTE_ON: begin
                note_hit = 1'b1;
                // Velocity 0 is the running-status idiom for note off.
                if (msg.data_byte2 != 7'd0) begin
                    note.state = ON;
                end else begin
                    note.velocity = 7'd0;
                end
            end
            NOTE_OFF:       note_hit = 1'b1;
            CONTROL_CHANGE: cc_hit   = is_mapped_controller(msg.data_byte1);
            default:        ;
        endcase
    end

endmodule

// File: rtl/midi_parser.sv
// midi_parser: turns a stream of received MIDI bytes into channel messages with
// running status, and decodes note and controller events.
// Parameters:
//   CHANNEL - channel accepted when OMNI=0
//   OMNI    - accept all 16 channels when 1
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   byte_valid, byte_data  - one received byte per cycle, no back-pressure
//   message_valid, message - one-cycle pulse + last emitted channel message (held)
//   note_change_valid/note_change       - pulse + last note event (held)
//   control_change_valid/control_change - pulse + last controller event (held)
module midi_parser
    import MIDI::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            message_valid,
    output message_t        message,
    output logic            note_change_valid,
    output note_change_t    note_change,
    output logic            control_change_valid,
    output control_change_t control_change
);

    typedef enum logic [1:0] {
        StIdle,
        StData1,
        StData2
    } state_t;

    state_t        state_q;
    message_type_t rs_type_q;
    logic [3:0]    rs_channel_q;
    logic [6:0]    data1_q;

    logic         complete;
    message_t     cand;
    logic         chan_ok;
    logic         note_hit;
    logic         cc_hit;
    note_change_t    dec_note;
    control_change_t dec_cc;

    assign chan_ok = OMNI || (rs_channel_q == CHANNEL);

    // Message formed by the byte on the bus, valid when complete is set.
    always_comb begin
        complete = 1'b0;
        cand     = '{message_type: rs_type_q, data_byte1: byte_data[6:0], data_byte2: 7'd0};
        if (byte_valid && byte_type_t'(byte_data[7]) == DATA) begin
            if (state_q == StData1 && data_byte_count(rs_type_q) == 2'd1) begin
                complete = 1'b1;
            end else if (state_q == StData2) begin
                complete        = 1'b1;
                cand.data_byte1 = data1_q;
                cand.data_byte2 = byte_data[6:0];
            end
        end
    end

    midi_message_decode u_decode (
        .msg      (cand),
        .note_hit (note_hit),
        .note     (dec_note),
        .cc_hit   (cc_hit),
        .cc       (dec_cc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= StIdle;
            rs_type_q            <= NONE;
            rs_channel_q         <= 4'd0;
            data1_q              <= 7'd0;
            message_valid        <= 1'b0;
            message              <= '{message_type: NONE, data_byte1: 7'd0, data_byte2: 7'd0};
            note_change_valid    <= 1'b0;
            note_change          <= '{state: OFF, note: 7'd0, velocity: 7'd0};
            control_change_valid <= 1'b0;
            control_change       <= '{controller: NO_CONTROLLER, value: 7'd0};
        end else begin
            message_valid        <= 1'b0;
            note_change_valid    <= 1'b0;
            control_change_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_type_t'(byte_data[7]) == STATUS) begin
                    if (byte_data[7:4] != 4'hF) begin
                        rs_type_q    <= message_type_t'(byte_data[7:4]);
                        rs_channel_q <= byte_data[3:0];
                        state_q      <= StData1;
                    end else if (!byte_data[3]) begin
                        // System common/exclusive cancels running status.
                        rs_type_q    <= NONE;
                        rs_channel_q <= 4'd0;
                        state_q      <= StIdle;
                    end
                    // 0xF8-0xFF real-time bytes fall through untouched.
                end else begin
                    unique case (state_q)
                        StIdle:  ;
                        StData1: begin
                            data1_q <= byte_data[6:0];
                            if (data_byte_count(rs_type_q) == 2'd2) begin
                                state_q <= StData2;
                            end
                        end
                        StData2: state_q <= StData1;
                    endcase
                    if (complete && chan_ok) begin
                        message_valid <= 1'b1;
                        message       <= cand;
                        if (note_hit) begin
                            note_change_valid <= 1'b1;
                            note_change       <= dec_note;
                        end
                        if (cc_hit) begin
                            control_change_valid <= 1'b1;
                            control_change       <= dec_cc;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Self-checking bench for midi_parser: an OMNI instance (A) and a CHANNEL=2
// filtered instance (B) share one byte stream; a queue-based reference model
// predicts every output each cycle.
module tb_midi_parser;
    import MIDI::*;

    logic clk;
    logic rst_n;
    logic byte_valid;
    logic [7:0] byte_data;

    logic mv_a, nv_a, cv_a, mv_b, nv_b, cv_b;
    message_t msg_a, msg_b;
    note_change_t note_a, note_b;
    control_change_t cc_a, cc_b;

    midi_parser u_dut_a (
        .clk                  (clk),
        .rst_n                (rst_n),
        .byte_valid           (byte_valid),
        .byte_data            (byte_data),
        .message_valid        (mv_a),
        .message              (msg_a),
        .note_change_valid    (nv_a),
        .note_change          (note_a),
        .control_change_valid (cv_a),
        .control_change       (cc_a)
    );

    midi_parser #(
        .CHANNEL (4'd2),
        .OMNI    (1'b0)
    ) u_dut_b (
        .clk                  (clk),
        .rst_n                (rst_n),
        .byte_valid           (byte_valid),
        .byte_data            (byte_data),
        .message_valid        (mv_b),
        .message              (msg_b),
        .note_change_valid    (nv_b),
        .note_change          (note_b),
        .control_change_valid (cv_b),
        .control_change       (cc_b)
    );

    wire [49:0] obs_a = {mv_a, msg_a, nv_a, note_a, cv_a, cc_a};
    wire [49:0] obs_b = {mv_b, msg_b, nv_b, note_b, cv_b, cc_b};

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    bit m_run;
    int m_type;
    int m_chan;
    int m_buf[$];
    logic            e_mv[2];
    logic [17:0]     e_msg[2];
    logic            e_nv[2];
    logic [14:0]     e_note[2];
    logic            e_cv[2];
    logic [13:0]     e_cc[2];

    function automatic logic [49:0] exp_vec(int k);
        return {e_mv[k], e_msg[k], e_nv[k], e_note[k], e_cv[k], e_cc[k]};
    endfunction

    function automatic void model_reset();
        m_run = 1'b0;
        m_type = 0;
        m_chan = 0;
        m_buf.delete();
        for (int k = 0; k < 2; k++) begin
            e_mv[k] = 1'b0; e_msg[k] = '0; e_nv[k] = 1'b0;
            e_note[k] = '0; e_cv[k] = 1'b0; e_cc[k] = '0;
        end
    endfunction

    function automatic void deliver(int k, int t, int d1, int d2);
        e_mv[k] = 1'b1;
        e_msg[k] = {4'(t), 7'(d1), 7'(d2)};
        if (t == 9 && d2 != 0) begin
            e_nv[k] = 1'b1; e_note[k] = {1'b1, 7'(d1), 7'(d2)};
        end else if (t == 9) begin
            e_nv[k] = 1'b1; e_note[k] = {1'b0, 7'(d1), 7'd0};
        end else if (t == 8) begin
            e_nv[k] = 1'b1; e_note[k] = {1'b0, 7'(d1), 7'(d2)};
        end else if (t == 11 && d1 >= 21 && d1 <= 28) begin
            e_cv[k] = 1'b1; e_cc[k] = {7'(d1), 7'(d2)};
        end
    endfunction

    function automatic void model_step(logic v, logic [7:0] b);
        int need;
        int d1;
        int d2;
        for (int k = 0; k < 2; k++) begin
            e_mv[k] = 1'b0; e_nv[k] = 1'b0; e_cv[k] = 1'b0;
        end
        if (!v || b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_run = 1'b0; m_buf.delete(); return;
        end
        if (b >= 8'h80) begin
            m_run = 1'b1; m_type = int'(b[7:4]); m_chan = int'(b[3:0]); m_buf.delete(); return;
        end
        if (!m_run) return;
        m_buf.push_back(int'(b));
        need = (m_type == 12 || m_type == 13) ? 1 : 2;
        if (m_buf.size() == need) begin
            d1 = m_buf[0];
            d2 = (need == 2) ? m_buf[1] : 0;
            m_buf.delete();
            deliver(0, m_type, d1, d2);
            if (m_chan == 2) deliver(1, m_type, d1, d2);
        end
    endfunction

    // Drive one cycle from a negedge; returns at the next negedge with outputs settled.
    task automatic send(input logic v, input logic [7:0] b);
        byte_valid = v;
        byte_data = b;
        model_step(v, b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        model_reset();
        @(negedge clk);
        checks += 2;
        if (obs_a !== 50'd0) begin errors++; $display("FAIL reset[A] got %h want 0", obs_a); end
        if (obs_b !== 50'd0) begin errors++; $display("FAIL reset[B] got %h want 0", obs_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_note_on();
        logic [7:0] seq[3] = '{8'h90, 8'h3C, 8'h64};
        for (int i = 0; i < 3; i++) begin
            send(1'b1, seq[i]);
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL note_on[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL note_on[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
        checks += 2;
        if ({mv_a, nv_a, msg_a} !== {1'b1, 1'b1, NOTE_ON, 7'h3C, 7'h64}) begin
            errors++; $display("FAIL note_on_msg got %b %b %h want 1 1 %h", mv_a, nv_a, msg_a, {NOTE_ON, 7'h3C, 7'h64});
        end
        if (note_a !== {ON, 7'd60, 7'd100}) begin
            errors++; $display("FAIL note_on_event got %h want %h", note_a, {ON, 7'd60, 7'd100});
        end
        send(1'b0, 8'h00);
    endtask

    task automatic test_running_status();
        logic [7:0] seq[5] = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, seq[i]);
            pulses += int'(nv_a);
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL running[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL running[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
        checks += 2;
        if (pulses != 2) begin errors++; $display("FAIL running_pulses got %0d want 2", pulses); end
        if (note_a !== {OFF, 7'd60, 7'd0}) begin
            errors++; $display("FAIL running_off got %h want %h", note_a, {OFF, 7'd60, 7'd0});
        end
        send(1'b0, 8'h00);
    endtask

    task automatic test_program_change();
        logic [7:0] seq[3] = '{8'hC0, 8'h05, 8'h07};
        logic [6:0] want[2] = '{7'd5, 7'd7};
        int n = 0;
        int other = 0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, seq[i]);
            other += int'(nv_a) + int'(cv_a);
            if (mv_a) begin
                checks++;
                if (n > 1 || msg_a !== {PROGRAM_CHANGE, want[n], 7'd0}) begin
                    errors++; $display("FAIL program_msg n=%0d got %h", n, msg_a);
                end
                n++;
            end
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL program[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL program[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
        checks += 2;
        if (n != 2) begin errors++; $display("FAIL program_count got %0d want 2", n); end
        if (other != 0) begin errors++; $display("FAIL program_decoded got %0d want 0", other); end
        send(1'b0, 8'h00);
    endtask

    task automatic test_control_change();
        logic [7:0] seq[8] = '{8'hB0, 8'hF8, 8'h18, 8'hF8, 8'h40, 8'hB0, 8'h07, 8'h40};
        int cc_pulses = 0;
        int msg_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, seq[i]);
            cc_pulses += int'(cv_a);
            msg_pulses += int'(mv_a);
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL control[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL control[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
        checks += 3;
        if (cc_a !== {ATTACK, 7'd64}) begin errors++; $display("FAIL control_event got %h want %h", cc_a, {ATTACK, 7'd64}); end
        if (cc_pulses != 1) begin errors++; $display("FAIL control_pulses got %0d want 1", cc_pulses); end
        if (msg_pulses != 2) begin errors++; $display("FAIL control_msgs got %0d want 2", msg_pulses); end
        send(1'b0, 8'h00);
    endtask

    task automatic test_channel_filter();
        logic [7:0] seq[6] = '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64};
        int pa = 0;
        int pb = 0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, seq[i]);
            pa += int'(mv_a);
            pb += int'(mv_b);
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL filter[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL filter[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
        checks += 2;
        if (pb != 1) begin errors++; $display("FAIL filter_b_pulses got %0d want 1", pb); end
        if (pa != 2) begin errors++; $display("FAIL filter_a_pulses got %0d want 2", pa); end
        send(1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_message();
        logic [7:0] seq[3] = '{8'h64, 8'h3C, 8'h64};
        send(1'b1, 8'h90);
        send(1'b1, 8'h3C);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks += 2;
        if (obs_a !== 50'd0) begin errors++; $display("FAIL mid_reset[A] got %h want 0", obs_a); end
        if (obs_b !== 50'd0) begin errors++; $display("FAIL mid_reset[B] got %h want 0", obs_b); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, seq[i]);
            checks += 2;
            if (obs_a !== 50'd0) begin errors++; $display("FAIL post_reset[A] i=%0d got %h want 0", i, obs_a); end
            if (obs_b !== 50'd0) begin errors++; $display("FAIL post_reset[B] i=%0d got %h want 0", i, obs_b); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic v;
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      b = 8'($urandom_range(0, 127));
            else if (r < 82) b = 8'(8'h80 + $urandom_range(0, 111));
            else if (r < 93) b = 8'(8'hF8 + $urandom_range(0, 7));
            else             b = 8'(8'hF0 + $urandom_range(0, 7));
            // Bias data bytes toward the mapped controller range now and then.
            if (r < 10) b = 8'(21 + $urandom_range(0, 7));
            v = ($urandom_range(0, 4) != 0);
            send(v, b);
            checks += 2;
            if (obs_a !== exp_vec(0)) begin errors++; $display("FAIL random[A] i=%0d got %h want %h", i, obs_a, exp_vec(0)); end
            if (obs_b !== exp_vec(1)) begin errors++; $display("FAIL random[B] i=%0d got %h want %h", i, obs_b, exp_vec(1)); end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_program_change();
        test_control_change();
        test_channel_filter();
        test_reset_mid_message();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
